i2c_temp_target: RTL and testbench

I2C target (responder) that emulates the on-board temperature sensor, answering the same transactions our `i2c_master` issues. It lets the master/display path run in loopback or simulation without the physical sensor. It oversamples SCL/SDA on the system clock, decodes START/STOP, and ACKs its 7-bit address. It serves a small register map (temperature MSB/LSB, ID) and accepts a register-pointer write.

---
 rtl/i2c_target_pkg.sv | 41 ++++
 rtl/i2c_line_sync.sv | 32 +++
 rtl/i2c_temp_target.sv | 172 +++++++++++++++++
 tb/tb_i2c_temp_target.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_target_pkg.sv
// Shared definitions for the emulated I2C temperature-sensor target.
package i2c_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_WR_DATA   = 3'd3,
        ST_WR_ACK    = 3'd4,
        ST_RD_DATA   = 3'd5,
        ST_RD_ACK    = 3'd6,
        ST_WAIT_STOP = 3'd7
    } state_t;

    localparam logic [7:0] PTR_TEMP_MSB = 8'h00;
    localparam logic [7:0] PTR_TEMP_LSB = 8'h01;
    localparam logic [7:0] PTR_ID       = 8'h0B;

    localparam int BIT_CNT_W = 4;
    typedef logic [BIT_CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_ZERO  = 4'd0;
    localparam cnt_t CNT_ONE   = 4'd1;
    localparam cnt_t CNT_SEVEN = 4'd7;
    localparam cnt_t CNT_EIGHT = 4'd8;

    // Register map decode; pointer 0x01 reads the snapshot so MSB/LSB match.
    function automatic logic [7:0] reg_read(input logic [7:0]  ptr,
                                            input logic [15:0] temp,
                                            input logic [15:0] snap,
                                            input logic [7:0]  dev_id);
        logic [7:0] val;
        case (ptr)
            PTR_TEMP_MSB: val = temp[15:8];
            PTR_TEMP_LSB: val = snap[7:0];
            PTR_ID:       val = dev_id;
            default:      val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer for one I2C pin with rise/fall detection.
// Flops reset to 1 because an idle I2C line is pulled high.
module i2c_line_sync (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta_r;
    logic sync_r;
    logic dly_r;

    // Synchronize the pin and keep a one-cycle delayed copy for edge detect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            dly_r  <= 1'b1;
        end else begin
            meta_r <= pin;
            sync_r <= meta_r;
            dly_r  <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~dly_r;
    assign fall  = ~sync_r & dly_r;

endmodule

// File: rtl/i2c_temp_target.sv
// I2C target emulating the temperature sensor: address match, pointer write,
// auto-incrementing reads of the temperature/ID register map.
module i2c_temp_target
    import i2c_target_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h4B,
    parameter logic [7:0] DEV_ID   = 8'hCB
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic        busy,
    output logic [7:0]  ptr_out
);
    logic scl_lvl_s, scl_rise_s, scl_fall_s;
    logic sda_lvl_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [7:0] rx_byte_s, rd_byte_s;

    state_t      state_r, state_nx;
    logic [7:0]  shift_r, shift_nx;
    logic [7:0]  tx_r, tx_nx;
    cnt_t        cnt_r, cnt_nx;
    logic [7:0]  ptr_r, ptr_nx;
    logic [15:0] snap_r, snap_nx;
    logic        sda_oe_r, sda_oe_nx;
    logic        busy_r, busy_nx;
    logic        rw_r, rw_nx;
    logic        first_r, first_nx;

    i2c_line_sync u_scl_sync (
        .clock (clock), .reset (reset), .pin (scl_in),
        .level (scl_lvl_s), .rise (scl_rise_s), .fall (scl_fall_s)
    );

    i2c_line_sync u_sda_sync (
        .clock (clock), .reset (reset), .pin (sda_in),
        .level (sda_lvl_s), .rise (sda_rise_s), .fall (sda_fall_s)
    );

    assign start_s   = scl_lvl_s & sda_fall_s;
    assign stop_s    = scl_lvl_s & sda_rise_s;
    assign rx_byte_s = {shift_r[6:0], sda_lvl_s};
    assign rd_byte_s = reg_read(ptr_r, temp_in, snap_r, DEV_ID);

    // Next-state and datapath updates; sda_oe only moves on a synced SCL fall.
    always_comb begin
        state_nx  = state_r;
        shift_nx  = shift_r;
        tx_nx     = tx_r;
        cnt_nx    = cnt_r;
        ptr_nx    = ptr_r;
        snap_nx   = snap_r;
        sda_oe_nx = sda_oe_r;
        busy_nx   = busy_r;
        rw_nx     = rw_r;
        first_nx  = first_r;
        if (start_s) begin
            state_nx  = ST_ADDR;
            cnt_nx    = CNT_ZERO;
            sda_oe_nx = 1'b0;
            first_nx  = 1'b1;
        end else if (stop_s) begin
            state_nx  = ST_IDLE;
            cnt_nx    = CNT_ZERO;
            sda_oe_nx = 1'b0;
            busy_nx   = 1'b0;
        end else begin
            case (state_r)
                ST_ADDR, ST_WR_DATA: begin
                    if (scl_rise_s && (cnt_r < CNT_EIGHT)) begin
                        shift_nx = rx_byte_s;
                        cnt_nx   = cnt_r + CNT_ONE;
                        if (cnt_r != CNT_SEVEN) begin
                            first_nx = first_r;
                        end else if (state_r == ST_WR_DATA) begin
                            // Only the first data byte of a transaction sets the pointer.
                            ptr_nx   = first_r ? rx_byte_s : ptr_r;
                            first_nx = 1'b0;
                        end else if (rx_byte_s[7:1] == DEV_ADDR) begin
                            busy_nx = 1'b1;
                            rw_nx   = rx_byte_s[0];
                        end else begin
                            state_nx = ST_WAIT_STOP;
                        end
                    end else if (scl_fall_s && (cnt_r == CNT_EIGHT)) begin
                        state_nx  = (state_r == ST_ADDR) ? ST_ADDR_ACK : ST_WR_ACK;
                        sda_oe_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt_r;
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK, ST_RD_ACK: begin
                    if (scl_rise_s && (state_r == ST_RD_ACK)) begin
                        ptr_nx = ptr_r + 8'd1;
                        if (sda_lvl_s) begin
                            state_nx = ST_WAIT_STOP;
                        end else begin
                            state_nx = state_r;
                        end
                    end else if (scl_fall_s && (state_r == ST_ADDR_ACK) && !rw_r) begin
                        state_nx  = ST_WR_DATA;
                        cnt_nx    = CNT_ZERO;
                        sda_oe_nx = 1'b0;
                    end else if (scl_fall_s && (state_r == ST_WR_ACK)) begin
                        state_nx  = ST_WR_DATA;
                        cnt_nx    = CNT_ZERO;
                        sda_oe_nx = 1'b0;
                    end else if (scl_fall_s) begin
                        // Load the next read byte and drive its MSB on this fall.
                        state_nx  = ST_RD_DATA;
                        tx_nx     = rd_byte_s;
                        cnt_nx    = CNT_ONE;
                        sda_oe_nx = ~rd_byte_s[7];
                        snap_nx   = (ptr_r == PTR_TEMP_MSB) ? temp_in : snap_r;
                    end else begin
                        state_nx = state_r;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall_s && (cnt_r == CNT_EIGHT)) begin
                        state_nx  = ST_RD_ACK;
                        sda_oe_nx = 1'b0;
                    end else if (scl_fall_s) begin
                        tx_nx     = {tx_r[6:0], 1'b0};
                        sda_oe_nx = ~tx_r[6];
                        cnt_nx    = cnt_r + CNT_ONE;
                    end else begin
                        tx_nx = tx_r;
                    end
                end
                ST_WAIT_STOP: sda_oe_nx = 1'b0;
                default:      state_nx  = state_r;
            endcase
        end
    end

    // State and datapath registers; reset abandons any transaction at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            shift_r  <= 8'h00;
            tx_r     <= 8'h00;
            cnt_r    <= CNT_ZERO;
            ptr_r    <= 8'h00;
            snap_r   <= 16'h0000;
            sda_oe_r <= 1'b0;
            busy_r   <= 1'b0;
            rw_r     <= 1'b0;
            first_r  <= 1'b0;
        end else begin
            state_r  <= state_nx;
            shift_r  <= shift_nx;
            tx_r     <= tx_nx;
            cnt_r    <= cnt_nx;
            ptr_r    <= ptr_nx;
            snap_r   <= snap_nx;
            sda_oe_r <= sda_oe_nx;
            busy_r   <= busy_nx;
            rw_r     <= rw_nx;
            first_r  <= first_nx;
        end
    end

    assign sda_oe  = sda_oe_r;
    assign busy    = busy_r;
    assign ptr_out = ptr_r;

endmodule

// File: tb/tb_i2c_temp_target.sv
// Directed bench for i2c_temp_target: a bit-banged I2C controller with an
// open-drain SDA model and hand-computed expected bytes.
module tb_i2c_temp_target;
    import i2c_target_pkg::*;

    localparam int Q = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_oe;
    logic [15:0] temp_in = 16'h0C80;
    logic        busy;
    logic [7:0]  ptr_out;
    logic        sda_line;
    logic        mon_en = 1'b0;
    logic        oe_seen;
    int          checks = 0;
    int          errors = 0;
    logic        ack;
    logic [7:0]  b;

    assign sda_line = sda_m & ~sda_oe;

    i2c_temp_target dut (
        .clock   (clock),
        .reset   (reset),
        .scl_in  (scl_m),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .temp_in (temp_in),
        .busy    (busy),
        .ptr_out (ptr_out)
    );

    always #5 clock = ~clock;

    // Remember whether the target ever pulled SDA while monitoring is on.
    always @(posedge clock) begin
        if (!mon_en) oe_seen <= 1'b0;
        else if (sda_oe) oe_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(posedge clock);
        #1;
    endtask

    task automatic scl_fall_hold();
        scl_m = 1'b0;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_fall_hold();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic a);
        for (int i = 7; i >= 0; i--) begin
            sda_m = d[i]; wq();
            scl_m = 1'b1; wq();
            scl_fall_hold();
        end
        sda_m = 1'b1; wq();
        scl_m = 1'b1;
        repeat (Q / 2) @(posedge clock);
        #1;
        a = sda_line;
        wq();
        scl_fall_hold();
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] d);
        sda_m = 1'b1;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wq();
            scl_m = 1'b1;
            repeat (Q / 2) @(posedge clock);
            #1;
            d = {d[6:0], sda_line};
            wq();
            scl_fall_hold();
        end
        sda_m = ack_bit; wq();
        scl_m = 1'b1; wq();
        scl_fall_hold();
        sda_m = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_sda_oe", {15'd0, sda_oe}, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_ptr", {8'd0, ptr_out}, 16'h0000);
        reset = 1'b1;
        wq();
        check("rst_state", {13'd0, dut.state_r}, {13'd0, ST_IDLE});

        // Addressed read of two bytes from pointer 0x00.
        i2c_start();
        write_byte(8'h97, ack);
        check("rd_addr_ack", {15'd0, ack}, 16'd0);
        check("rd_busy", {15'd0, busy}, 16'd1);
        read_byte(1'b0, b);
        check("rd_byte0", {8'd0, b}, 16'h000C);
        read_byte(1'b1, b);
        check("rd_byte1", {8'd0, b}, 16'h0080);
        i2c_stop();
        check("rd_ptr", {8'd0, ptr_out}, 16'h0002);
        check("rd_busy_after_stop", {15'd0, busy}, 16'd0);

        // Pointer write, then repeated-start read of the ID.
        i2c_start();
        write_byte(8'h96, ack);
        check("pw_addr_ack", {15'd0, ack}, 16'd0);
        write_byte(8'h0B, ack);
        check("pw_data_ack", {15'd0, ack}, 16'd0);
        i2c_start();
        write_byte(8'h97, ack);
        check("pw_raddr_ack", {15'd0, ack}, 16'd0);
        read_byte(1'b1, b);
        check("pw_id", {8'd0, b}, 16'h00CB);
        i2c_stop();
        check("pw_ptr", {8'd0, ptr_out}, 16'h000C);

        // Wrong address: no ACK, no SDA drive, parks in WAIT_STOP.
        mon_en = 1'b1;
        i2c_start();
        write_byte(8'h90, ack);
        check("wa_no_ack", {15'd0, ack}, 16'd1);
        check("wa_state", {13'd0, dut.state_r}, {13'd0, ST_WAIT_STOP});
        check("wa_busy", {15'd0, busy}, 16'd0);
        i2c_stop();
        check("wa_oe_never", {15'd0, oe_seen}, 16'd0);
        check("wa_idle", {13'd0, dut.state_r}, {13'd0, ST_IDLE});
        mon_en = 1'b0;

        // Snapshot: temp_in changes after the MSB is loaded; LSB stays 0x80.
        i2c_start();
        write_byte(8'h96, ack);
        write_byte(8'h00, ack);
        i2c_start();
        write_byte(8'h97, ack);
        check("sn_addr_ack", {15'd0, ack}, 16'd0);
        fork
            read_byte(1'b0, b);
            begin
                repeat (40) @(posedge clock);
                temp_in = 16'h0D00;
            end
        join
        check("sn_msb", {8'd0, b}, 16'h000C);
        read_byte(1'b1, b);
        check("sn_lsb", {8'd0, b}, 16'h0080);
        i2c_stop();

        // Pointer wrap 0xFF -> 0x00.
        temp_in = 16'h0C80;
        i2c_start();
        write_byte(8'h96, ack);
        write_byte(8'hFF, ack);
        i2c_start();
        write_byte(8'h97, ack);
        read_byte(1'b0, b);
        check("wr_byte_ff", {8'd0, b}, 16'h0000);
        read_byte(1'b1, b);
        check("wr_byte_00", {8'd0, b}, 16'h000C);
        i2c_stop();
        check("wr_ptr", {8'd0, ptr_out}, 16'h0001);

        // Reset mid-read: pointer 0x01 returns 0x80, bit 3 is driven low.
        i2c_start();
        write_byte(8'h97, ack);
        check("mr_addr_ack", {15'd0, ack}, 16'd0);
        sda_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wq();
            scl_m = 1'b1; wq();
            scl_fall_hold();
        end
        wq();
        check("mr_bit3_driven", {15'd0, sda_oe}, 16'd1);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mr_oe_async", {15'd0, sda_oe}, 16'd0);
        check("mr_ptr", {8'd0, ptr_out}, 16'h0000);
        check("mr_busy", {15'd0, busy}, 16'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        scl_m = 1'b1;
        wq();
        temp_in = 16'h00A5;
        i2c_start();
        write_byte(8'h97, ack);
        check("mr2_addr_ack", {15'd0, ack}, 16'd0);
        read_byte(1'b0, b);
        check("mr2_msb", {8'd0, b}, 16'h0000);
        read_byte(1'b1, b);
        check("mr2_lsb", {8'd0, b}, 16'h00A5);
        i2c_stop();
        check("mr2_ptr", {8'd0, ptr_out}, 16'h0002);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
